// File: rtl/cache_op_scheduler.sv
// cache_op_scheduler
//   Sequences one trace command at a time through the split L1 cache datapath:
//   lookup -> optional victim writeback -> optional L2 fill -> commit.
//   Only one L2 transaction is outstanding at a time. Hit/miss/read/write
//   statistics are kept, and an L2 that never acknowledges raises a sticky err.
//
//   Optional feature macro: CACHE_SCHED_STATS_EN
//     defined     -> four saturating statistics counters are implemented
//     not defined -> counter outputs are tied to zero (no counter flops)
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd/cmd_ready    trace command handshake
//   cmd_q                      captured command, drives the datapath instruction input
//   lookup_hit, victim_dirty   datapath lookup results for cmd_q
//   proc_en                    one-cycle commit strobe to the datapath
//   l2_req/l2_op/l2_ack        L2 transaction (op 00 READ, 01 RWIM, 10 WRITE)
//   busy, err                  state != IDLE, sticky L2 timeout flag
//   read_cnt .. miss_cnt       statistics counters

package cache_sched_pkg;
    typedef struct packed {
        logic [3:0]  n;        // trace operation code
        logic [31:0] address;  // byte address
    } command_t;
endpackage

module cache_op_scheduler
    import cache_sched_pkg::*;
#(
    parameter int L2_TIMEOUT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  command_t         cmd,
    output logic             cmd_ready,
    output command_t         cmd_q,
    input  logic             lookup_hit,
    input  logic             victim_dirty,
    output logic             proc_en,
    output logic             l2_req,
    output logic [1:0]       l2_op,
    input  logic             l2_ack,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] read_cnt,
    output logic [CNT_W-1:0] write_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int WAIT_W = $clog2(L2_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_COMMIT, S_CLEAR
    } state_t;

    state_t            r_state;
    command_t          r_cmd_q;
    logic              r_proc_en;
    logic              r_l2_req;
    logic [1:0]        r_l2_op;
    logic              r_err;
    logic [WAIT_W-1:0] r_wait;

    logic [3:0] w_n;
    logic       w_handshake;
    logic       w_timeout;
    logic       w_no_l2;
    logic [1:0] w_fill_op;

    assign w_n         = r_cmd_q.n;
    assign cmd_ready   = (r_state == S_IDLE) & rst_n;
    assign w_handshake = cmd_valid & cmd_ready;
    // r_wait counts completed request cycles; this is the last allowed one
    assign w_timeout   = (r_wait == WAIT_W'(L2_TIMEOUT - 1));
    // ops 3/4 commit straight away without touching L2
    assign w_no_l2     = (w_n == 4'd3) || (w_n == 4'd4);
    assign w_fill_op   = (w_n == 4'd1) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cmd_q   <= '0;
            r_proc_en <= 1'b0;
            r_l2_req  <= 1'b0;
            r_l2_op   <= 2'b00;
            r_err     <= 1'b0;
            r_wait    <= '0;
        end else begin
            r_proc_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_cmd_q <= cmd;
                        if (cmd.n <= 4'd4)
                            r_state <= S_LOOKUP;
                        else if (cmd.n == 4'd8)
                            r_state <= S_CLEAR;
                        // any other op is consumed with no effect
                    end
                end
                S_LOOKUP: begin
                    if (w_no_l2 || lookup_hit) begin
                        r_state   <= S_COMMIT;
                        r_proc_en <= 1'b1;
                    end else if (victim_dirty && (w_n <= 4'd1)) begin
                        r_state  <= S_WB_REQ;
                        r_l2_req <= 1'b1;
                        r_l2_op  <= 2'b10;
                        r_wait   <= '0;
                    end else begin
                        r_state  <= S_FILL_REQ;
                        r_l2_req <= 1'b1;
                        r_l2_op  <= w_fill_op;
                        r_wait   <= '0;
                    end
                end
                S_WB_REQ: begin
                    if (l2_ack) begin
                        // enter FILL_REQ with the request low for one cycle
                        r_state  <= S_FILL_REQ;
                        r_l2_req <= 1'b0;
                        r_l2_op  <= 2'b00;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_l2_req <= 1'b0;
                        r_l2_op  <= 2'b00;
                        r_err    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FILL_REQ: begin
                    if (!r_l2_req) begin
                        // gap cycle after a writeback: start the fill now;
                        // an ack here belongs to no request and is ignored
                        r_l2_req <= 1'b1;
                        r_l2_op  <= w_fill_op;
                        r_wait   <= '0;
                    end else if (l2_ack) begin
                        r_state   <= S_COMMIT;
                        r_proc_en <= 1'b1;
                        r_l2_req  <= 1'b0;
                        r_l2_op   <= 2'b00;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_l2_req <= 1'b0;
                        r_l2_op  <= 2'b00;
                        r_err    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_COMMIT: r_state <= S_IDLE;
                S_CLEAR: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_q   = r_cmd_q;
    assign proc_en = r_proc_en;
    assign l2_req  = r_l2_req;
    assign l2_op   = r_l2_op;
    assign err     = r_err;
    assign busy    = (r_state != S_IDLE);

`ifdef CACHE_SCHED_STATS_EN
    logic [CNT_W-1:0] r_read_cnt;
    logic [CNT_W-1:0] r_write_cnt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_count;

    // only ops 0/1/2 are statistics-relevant, counted as LOOKUP is left
    assign w_count = (r_state == S_LOOKUP) && (w_n <= 4'd2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_cnt  <= '0;
            r_write_cnt <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else if (r_state == S_CLEAR) begin
            r_read_cnt  <= '0;
            r_write_cnt <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else if (w_count) begin
            if (w_n == 4'd1)
                r_write_cnt <= sat_inc(r_write_cnt);
            else
                r_read_cnt <= sat_inc(r_read_cnt);
            if (lookup_hit)
                r_hit_cnt <= sat_inc(r_hit_cnt);
            else
                r_miss_cnt <= sat_inc(r_miss_cnt);
        end
    end

    assign read_cnt  = r_read_cnt;
    assign write_cnt = r_write_cnt;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
`else
    assign read_cnt  = '0;
    assign write_cnt = '0;
    assign hit_cnt   = '0;
    assign miss_cnt  = '0;
`endif

endmodule
